// File: rtl/dmem_pipe.sv
// dmem_pipe: handshaked data memory for the pipelined miniRV core.
// Byte/half/word stores with byte enables, sign/zero-extended loads, one
// outstanding request, configurable load latency (RD_LAT = 1..4).
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned half/word
// accesses are flagged with err_o and never modify the array). Without it,
// err_o is always 0 and half/word addresses are forced into alignment.
module dmem_pipe #(
    parameter int AW     = 14,
    parameter int RD_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        ready_o,
    input  logic        we_i,
    input  logic        sign_i,
    input  logic [1:0]  mask_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_bad_rd_lat
        $error("dmem_pipe: RD_LAT must lie in 1..4");
    end

    // Last BUSY count before a load response; 0 means respond on the accept edge.
    localparam logic [1:0] LOAD_PT = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Lane offset actually used: half drops addr[0], word drops addr[1:0].
    function automatic logic [1:0] eff_off(input logic [1:0] op, input logic [1:0] off);
        logic [1:0] r;
        case (op)
            2'b00:   r = off;
            2'b01:   r = {off[1], 1'b0};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
    // Half needs addr[0]=0, word (and reserved) needs addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] off);
        logic m;
        case (op)
            2'b00:   m = 1'b0;
            2'b01:   m = off[0];
            default: m = (off != 2'b00);
        endcase
        return m;
    endfunction
`endif

    // Byte enables for a store at the (already aligned) lane offset.
    function automatic logic [3:0] byte_en(input logic [1:0] op, input logic [1:0] off);
        logic [3:0] r;
        case (op)
            2'b00:   r = 4'b0001 << off;
            2'b01:   r = 4'b0011 << {off[1], 1'b0};
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    // Store data replicated across all lanes so any enabled lane sees it.
    function automatic logic [31:0] lane_data(input logic [1:0] op, input logic [31:0] d);
        logic [31:0] r;
        case (op)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Select the addressed lane, shift it to bit 0 and extend; words pass through.
    function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] op,
                                             input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    logic [31:0]   ram_q [2**AW];

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    op_q, op_d;
    logic [1:0]    off_q, off_d;
    logic          sign_q, sign_d;
    logic          mis_q, mis_d;

    logic [AW-1:0] idx_in_s;
    logic [1:0]    off_in_s;
    logic          mis_in_s;
    logic [3:0]    be_s;
    logic [31:0]   lane_s;
    logic          wr_en_s;
    logic [AW-1:0] rd_idx_s;
    logic [31:0]   rd_word_s;
    logic          unused_s;

    // Address bits above the array are intentionally dropped (aliasing).
    assign unused_s = ^addr_i[31:AW+2];

    // Decode the incoming request: index, lane, alignment, store lanes.
    always_comb begin
        idx_in_s = addr_i[AW+1:2];
        off_in_s = eff_off(mask_op_i, addr_i[1:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_in_s = is_misaligned(mask_op_i, addr_i[1:0]);
`else
        mis_in_s = 1'b0;
`endif
        be_s     = byte_en(mask_op_i, off_in_s);
        lane_s   = lane_data(mask_op_i, wdata_i);
        wr_en_s  = req_i & ready_q & we_i & ~mis_in_s;
    end

    // Read port: incoming address while idle, captured address while in flight.
    always_comb begin
        if (state_q == ST_IDLE) begin
            rd_idx_s = idx_in_s;
        end else begin
            rd_idx_s = idx_q;
        end
        rd_word_s = ram_q[rd_idx_s];
    end

    // Byte-enabled store into the array on the accept edge; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    ram_q[idx_in_s][8*b +: 8] <= lane_s[8*b +: 8];
                end
            end
        end
    end

    // Request FSM next state and next registered outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ready_d      = ready_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        idx_d        = idx_q;
        op_d         = op_q;
        off_d        = off_q;
        sign_d       = sign_q;
        mis_d        = mis_q;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (req_i) begin
                    idx_d   = idx_in_s;
                    op_d    = mask_op_i;
                    off_d   = off_in_s;
                    sign_d  = sign_i;
                    mis_d   = mis_in_s;
                    cnt_d   = 2'd0;
                    ready_d = 1'b0;
                    // Stores and single-cycle loads reach their response point right away.
                    if (we_i || (LOAD_PT == 2'd0)) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        err_d        = mis_in_s;
                        if (we_i) begin
                            rdata_d = rdata_q;
                        end else if (mis_in_s) begin
                            rdata_d = 32'h0000_0000;
                        end else begin
                            rdata_d = load_fmt(rd_word_s, mask_op_i, off_in_s, sign_i);
                        end
                    end else begin
                        state_d = ST_BUSY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Only loads with RD_LAT > 1 pass through here.
                cnt_d = cnt_q + 2'd1;
                if (cnt_d == LOAD_PT) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    err_d        = mis_q;
                    if (mis_q) begin
                        rdata_d = 32'h0000_0000;
                    end else begin
                        rdata_d = load_fmt(rd_word_s, op_q, off_q, sign_q);
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            err_q        <= 1'b0;
            idx_q        <= {AW{1'b0}};
            op_q         <= 2'b00;
            off_q        <= 2'b00;
            sign_q       <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            idx_q        <= idx_d;
            op_q         <= op_d;
            off_q        <= off_d;
            sign_q       <= sign_d;
            mis_q        <= mis_d;
        end
    end

    assign ready_o      = ready_q;
    assign resp_valid_o = resp_valid_q;
    assign rdata_o      = rdata_q;
    assign err_o        = err_q;

endmodule
